// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// default oversampling factor and the baud divisor used by baud_gen.
package uart_tx_ctrl_pkg;

    // clk cycles between baud ticks produced by baud_gen
    localparam int DIVISOR        = 4;
    // default baud ticks per serial bit
    localparam int DEF_OVERSAMPLE = 16;
    // counter widths: tick_cnt covers OVERSAMPLE up to 255, bit_cnt covers 8 data bits
    localparam int TICK_CNT_W     = 8;
    localparam int BIT_CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake into the transmit controller.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Serialises start, data (LSB first), optional
// parity and stop bits, holding each bit for OVERSAMPLE baud ticks. The tick
// comes from an external baud_gen so the receiver can share it.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           tick,
    uart_tx_ctrl_if.slave  host,
    output logic           tx,
    output logic           busy
);

    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0]  DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

    tx_state_t              state;
    logic [TICK_CNT_W-1:0]  tick_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   sh;
    logic                   par;
    logic                   bit_end;

    // current serial bit has been held for its full OVERSAMPLE ticks
    assign bit_end = tick && (tick_cnt == TICK_LAST);

    // handshake and status are decoded from the state register only
    assign host.tx_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    // frame sequencer; tx is driven from this register so the pad never glitches
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            par      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (host.tx_valid) begin
                        sh       <= host.tx_data;
                        par      <= (^host.tx_data) ^ 1'(PARITY_ODD);
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ALIGN;
                    end
                end

                // start edge is placed on a tick so the start bit gets full width
                ALIGN: begin
                    if (tick) begin
                        tx       <= 1'b0;
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end

                START, DATA, PARITY, STOP: begin
                    if (tick && !bit_end) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end else if (bit_end) begin
                        tick_cnt <= '0;
                        case (state)
                            START: begin
                                tx      <= sh[0];
                                bit_cnt <= '0;
                                state   <= DATA;
                            end
                            DATA: begin
                                if (bit_cnt == DATA_LAST) begin
                                    bit_cnt <= '0;
                                    if (PARITY_EN != 0) begin
                                        tx    <= par;
                                        state <= PARITY;
                                    end else begin
                                        tx    <= 1'b1;
                                        state <= STOP;
                                    end
                                end else begin
                                    // next bit comes from sh[1] before the shift lands
                                    tx      <= sh[1];
                                    sh      <= {1'b0, sh[DATA_BITS-1:1]};
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            PARITY: begin
                                tx      <= 1'b1;
                                bit_cnt <= '0;
                                state   <= STOP;
                            end
                            default: begin
                                tx <= 1'b1;
                                if (bit_cnt == STOP_LAST) begin
                                    bit_cnt <= '0;
                                    state   <= IDLE;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
